maxbin_detect: RTL

//  Finds the FFT bin with the largest power and hands it to the beamformer weighting block.
//  - Scans FFT RAM 1 after each FFT frame and finds the peak |X|^2 bin.
//  - Publishes that bin on maxbin and parks rdaddr1 on it.
//  - Pulses detectdone, which starts the weighting block; it then reads all four RAMs at maxbin.
//  - Waits for the weighting block's done before accepting the next frame.

---
 rtl/maxbin_pkg.sv | 17 +
 rtl/maxbin_detect_if.sv | 25 ++
 rtl/fd_magsq.sv | 24 ++
 rtl/maxbin_detect.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/maxbin_pkg.sv
// Shared widths and FSM state encoding for the FFT peak-bin detector.
package maxbin_pkg;

    localparam int BIN_W  = 10;
    localparam int SAMP_W = 14;
    localparam int PWR_W  = 29;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        SETTLE,
        PULSE,
        HOLD
    } state_t;

endpackage

// File: rtl/maxbin_detect_if.sv
// FFT RAM 1 read port plus the detector/weighting-block handshake.
interface maxbin_detect_if;
    import maxbin_pkg::*;

    logic                  fftdone;
    logic                  wbdone;
    logic [2*SAMP_W-1:0]   ramq1;
    logic [BIN_W-1:0]      rdaddr1;
    logic [BIN_W-1:0]      maxbin;
    logic [PWR_W-1:0]      maxpwr;
    logic                  detectdone;
    logic                  busy;
    logic                  overrun;

    modport master (
        output fftdone, wbdone, ramq1,
        input  rdaddr1, maxbin, maxpwr, detectdone, busy, overrun
    );

    modport slave (
        input  fftdone, wbdone, ramq1,
        output rdaddr1, maxbin, maxpwr, detectdone, busy, overrun
    );

endinterface

// File: rtl/fd_magsq.sv
// Combinational |X|^2 of a packed {re, im} signed sample; result is zero-extended, never saturates.
module fd_magsq
    import maxbin_pkg::*;
(
    input  logic [2*SAMP_W-1:0] samp_i,
    output logic [PWR_W-1:0]    pwr_o
);

    logic [SAMP_W-1:0]   re, im, re_abs, im_abs;
    logic [2*SAMP_W-1:0] re_sq, im_sq;

    assign re = samp_i[2*SAMP_W-1:SAMP_W];
    assign im = samp_i[SAMP_W-1:0];

    // Squaring the magnitude keeps the multiply unsigned; -8192 maps to 8192, which still fits.
    assign re_abs = re[SAMP_W-1] ? (~re + SAMP_W'(1)) : re;
    assign im_abs = im[SAMP_W-1] ? (~im + SAMP_W'(1)) : im;

    assign re_sq = {{SAMP_W{1'b0}}, re_abs} * {{SAMP_W{1'b0}}, re_abs};
    assign im_sq = {{SAMP_W{1'b0}}, im_abs} * {{SAMP_W{1'b0}}, im_abs};

    assign pwr_o = {1'b0, re_sq} + {1'b0, im_sq};

endmodule

// File: rtl/maxbin_detect.sv
// Scans FFT RAM 1 for the peak-power bin after each frame and hands it to the weighting block.
// Build option MAXBIN_THRESH_EN: frames whose peak power is below THRESH end without detectdone.
//
//   state  | meaning
//   IDLE   | waiting for fftdone, rdaddr1 parked on maxbin
//   SCAN   | issuing read addresses BIN_LO..BIN_HI
//   DRAIN  | last RD_LAT samples still in flight
//   SETTLE | rdaddr1 held on maxbin until RAM outputs are valid
//   PULSE  | detectdone high for one cycle
//   HOLD   | waiting for wbdone
module maxbin_detect
    import maxbin_pkg::*;
#(
    parameter int               BIN_LO = 1,
    parameter int               BIN_HI = 511,
    parameter int               RD_LAT = 2,
    parameter logic [PWR_W-1:0] THRESH = '0
) (
    input  logic           clk,
    input  logic [3:0]     KEY,
    maxbin_detect_if.slave bus
);

    localparam int               CNT_W  = $clog2(RD_LAT + 1);
    localparam logic [BIN_W-1:0] LO_B   = BIN_LO[BIN_W-1:0];
    localparam logic [BIN_W-1:0] HI_B   = BIN_HI[BIN_W-1:0];
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(RD_LAT - 1);

    logic rst_n;
    assign rst_n = KEY[0];

    logic unused_cfg;
    assign unused_cfg = ^{KEY[3:1], THRESH};

    state_t           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIN_W-1:0] addr_q, addr_d;
    logic [BIN_W-1:0] maxbin_q, maxbin_d;
    logic [PWR_W-1:0] maxpwr_q, maxpwr_d;
    logic             overrun_q;
    logic [RD_LAT-1:0] vld_q;
    logic [BIN_W-1:0]  bin_q [RD_LAT];
    logic [PWR_W-1:0]  pwr;

    fd_magsq u_magsq (
        .samp_i (bus.ramq1),
        .pwr_o  (pwr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= IDLE;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        case (st_q)
            IDLE:   if (bus.fftdone) st_d = SCAN;
            SCAN:   if (addr_q == HI_B) begin
                        st_d  = DRAIN;
                        cnt_d = LAT_M1;
                    end
            DRAIN:  if (cnt_q == '0) begin
`ifdef MAXBIN_THRESH_EN
                        // Use the next peak: the final sample may raise maxpwr on this very edge.
                        if (maxpwr_d < THRESH) begin
                            st_d = IDLE;
                        end else begin
                            st_d  = SETTLE;
                            cnt_d = LAT_M1;
                        end
`else
                        st_d  = SETTLE;
                        cnt_d = LAT_M1;
`endif
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
            SETTLE: if (cnt_q == '0) st_d = PULSE;
                    else             cnt_d = cnt_q - CNT_W'(1);
            PULSE:  st_d = HOLD;
            HOLD:   if (bus.wbdone) st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    always_comb begin
        bus.rdaddr1    = (st_q == SCAN) ? addr_q : maxbin_q;
        bus.detectdone = (st_q == PULSE);
        bus.busy       = (st_q != IDLE);
        bus.maxbin     = maxbin_q;
        bus.maxpwr     = maxpwr_q;
        bus.overrun    = overrun_q;
    end

    always_comb begin
        addr_d   = addr_q;
        maxbin_d = maxbin_q;
        maxpwr_d = maxpwr_q;
        if (st_q == IDLE && bus.fftdone) begin
            addr_d   = LO_B;
            maxbin_d = LO_B;
            maxpwr_d = '0;
        end else begin
            if (st_q == SCAN) addr_d = addr_q + BIN_W'(1);
            if (vld_q[RD_LAT-1] && pwr > maxpwr_q) begin
                maxbin_d = bin_q[RD_LAT-1];
                maxpwr_d = pwr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            maxbin_q  <= '0;
            maxpwr_q  <= '0;
            overrun_q <= 1'b0;
            vld_q     <= '0;
            for (int i = 0; i < RD_LAT; i++) bin_q[i] <= '0;
        end else begin
            addr_q    <= addr_d;
            maxbin_q  <= maxbin_d;
            maxpwr_q  <= maxpwr_d;
            overrun_q <= overrun_q | (bus.fftdone && st_q != IDLE);
            vld_q[0]  <= (st_q == SCAN);
            bin_q[0]  <= addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                bin_q[i] <= bin_q[i-1];
            end
        end
    end

endmodule
